if_prefetch: RTL and testbench
==============================

Name: if_prefetch

Overview:
- Instruction-fetch stage sitting directly upstream of the synchronous-free instruction ROM (combinational read: ce/addr in, 32-bit word out same cycle).
- Generates the PC and ROM chip-enable, captures each returned word with its PC into a small prefetch queue, and presents the queue head to the IF/ID register.
- Handles decode stalls, branch redirect with MIPS delay-slot preservation, and exception flush.

Parameters:
- DEPTH, 4, prefetch queue entries (power of 2, >=2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rom_ce_o  out  1  ROM chip enable (1 = ChipEnable)
- rom_addr_o  out  32  byte address to ROM (word-aligned, = pc)
- rom_inst_i  in  32  ROM read data, valid same cycle as rom_addr_o when rom_ce_o=1
- id_ready_i  in  1  IF/ID accepts head this cycle (= not stalled)
- id_valid_o  out  1  queue head valid
- id_pc_o  out  32  head PC (ZeroWord when !id_valid_o)
- id_inst_o  out  32  head instruction (ZeroWord when !id_valid_o)
- branch_flag_i  in  1  ID resolved a taken branch/jump this cycle
- branch_target_i  in  32  branch target address
- flush_i  in  1  exception/eret flush
- new_pc_i  in  32  handler/return address on flush

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, rom_ce_o=0, count=0, rd/wr pointers=0, id_valid_o=0, id_pc_o=id_inst_o=0. rom_ce_o rises on first clk edge after rst falls; first push one cycle later.
- rom_addr_o = pc always; ROM returns ZeroWord when ce=0, which is never pushed.
- pop = id_valid_o & id_ready_i. push = rom_ce_o & (count<DEPTH | pop) & !flush_i & !branch_flag_i.
- Normal push: enqueue {pc, rom_inst_i}; pc <= pc+4 (mod 2^32, wraps FFFF_FFFC->0000_0000). No push => pc holds.
- Simultaneous push+pop on full queue allowed; count unchanged.
- Head outputs are registered queue contents: ROM-to-id_valid_o latency = 1 cycle; no bypass.
- Priority: flush_i > branch_flag_i > normal.
- flush_i: queue emptied (count=0), pc <= new_pc_i, no push; id_valid_o=0 next cycle; new_pc_i pushed the cycle after.
- branch_flag_i (delay slot): D = head if count>0, else current fetch {pc, rom_inst_i} (rom_ce_o=1).
  - pop this cycle => D delivered; queue emptied.
  - no pop => queue becomes exactly {D}; count=1.
  - pc <= branch_target_i; target fetched/pushed next cycle.
- branch_flag_i while count=0 and rom_ce_o=0 (only possible the cycle after reset): queue stays empty, pc <= target.
- rst mid-operation: all state returns to reset values immediately, independent of clk.
- No X on outputs after reset; unaligned targets fetched as given (ROM ignores addr[1:0]).

Decomposition:
- Shared def.v constants: InstAddrBus, InstBus, ZeroWord, ChipEnable/ChipDisable, RstEnable, WriteEnable.
- Sub-module if_fifo: DEPTH-entry 64-bit FIFO (pc, inst) with push, pop, clear, keep_head_or_load controls, count/full/empty outputs.
- if_prefetch owns pc register, ce register, and redirect/delay-slot logic.

Test Plan:
- Reset release, ROM word at addr k = 32'h1000_0000+k, id_ready_i=1 -> rom_ce_o=1 cycle 1, id_valid_o=1 cycle 2 with pc=0, inst=1000_0000; then pc 4, 8, ... one per cycle.
- id_ready_i=0 for 8 cycles -> 4 entries (pc 0,4,8,C), pc holds at 10, head stays pc=0; re-enable -> pops 0,4,8,C,10 in order with no gaps.
- Queue holding pc 20,24,28, id_ready_i=0, branch_flag_i=1, target=100 -> next cycle queue={pc 20}, then pc 100, 104 follow.
- Same with id_ready_i=1 -> pc 20 delivered that cycle; next deliveries 100, 104; 24/28 never appear.
- Queue empty, branch at pc=40 with id_ready_i=0 -> queue={40, inst@40}, then 200 (target); flush_i+branch_flag_i together, new_pc_i=180, target=200 -> only 180, 184 delivered.
- rst pulsed mid-stream between clock edges -> id_valid_o=0, rom_ce_o=0 immediately; restart from RESET_PC; pc wrap FFFF_FFFC -> 0000_0000.

Source files
------------

// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and its prefetch queue.
package if_prefetch_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic [31:0] ZeroWord    = '0;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;
  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_t;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_RUN
  } fetch_state_t;

endpackage

// File: rtl/if_fifo.sv
// Prefetch queue of {pc, inst} pairs; clear and single-entry load override push/pop.
module if_fifo
  import if_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic                     keep_head_or_load,
  input  fetch_t                   push_data,
  input  fetch_t                   load_data,
  output fetch_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (keep_head_or_load) begin
      // Queue collapses to exactly one entry at slot 0.
      mem[0] <= load_data;
      rd_ptr <= '0;
      wr_ptr <= PW'(1);
      count  <= CW'(1);
    end else begin
      if (push == WriteEnable) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: PC/ROM enable generation, prefetch queue feeding IF/ID,
// branch redirect with delay-slot preservation and exception flush.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i
);

  fetch_state_t            state;
  fetch_state_t            state_nxt;
  logic [31:0]             pc;
  logic                    pop;
  logic                    push;
  logic                    fifo_clear;
  logic                    fifo_load;
  logic                    idle_empty;
  fetch_t                  head;
  fetch_t                  fetch_word;
  fetch_t                  delay_slot;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE: state_nxt = FETCH_RUN;
      FETCH_RUN:  state_nxt = FETCH_RUN;
      default:    state_nxt = FETCH_IDLE;
    endcase
  end

  always_comb begin
    rom_ce_o = ChipDisable;
    if (state == FETCH_RUN) begin
      rom_ce_o = ChipEnable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      pc <= RESET_PC;
    end else if (flush_i) begin
      pc <= new_pc_i;
    end else if (branch_flag_i) begin
      pc <= branch_target_i;
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  // The delay slot is the oldest unconsumed instruction: queue head if any,
  // otherwise the word the ROM is returning right now.
  always_comb begin
    pop        = id_valid_o & id_ready_i;
    push       = rom_ce_o & (!full | pop) & !flush_i & !branch_flag_i;
    idle_empty = empty & (rom_ce_o == ChipDisable);
    fetch_word = '{pc: pc, inst: rom_inst_i};
    delay_slot = empty ? fetch_word : head;
    fifo_clear = flush_i | (branch_flag_i & (pop | idle_empty));
    fifo_load  = branch_flag_i & !flush_i & !pop & !idle_empty;
  end

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk               (clk),
    .rst               (rst),
    .push              (push),
    .pop               (pop),
    .clear             (fifo_clear),
    .keep_head_or_load (fifo_load),
    .push_data         (fetch_word),
    .load_data         (delay_slot),
    .head              (head),
    .count             (count),
    .full              (full),
    .empty             (empty)
  );

  always_comb begin
    rom_addr_o = pc;
    id_valid_o = (count != '0);
    id_pc_o    = id_valid_o ? head.pc   : ZeroWord;
    id_inst_o  = id_valid_o ? head.inst : ZeroWord;
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: scoreboard of expected delivered PCs against a ROM
// whose word at address k is 32'h1000_0000 + k.
module tb_if_prefetch;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        br;
  logic [31:0] tgt;
  logic        fl;
  logic [31:0] npc;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q [$];

  if_prefetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce),
    .rom_addr_o      (rom_addr),
    .rom_inst_i      (rom_inst),
    .id_ready_i      (id_ready),
    .id_valid_o      (id_valid),
    .id_pc_o         (id_pc),
    .id_inst_o       (id_inst),
    .branch_flag_i   (br),
    .branch_target_i (tgt),
    .flush_i         (fl),
    .new_pc_i        (npc)
  );

  assign rom_inst = rom_ce ? (32'h1000_0000 + rom_addr) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_q.push_back(p);
  endtask

  // Called at a negedge with inputs already set; checks any delivery, then advances one cycle.
  task automatic tick();
    logic [31:0] e;
    #1;
    if (id_valid && id_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_delivery observed=%h expected=none", id_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("deliver_pc", id_pc, e);
        chk("deliver_inst", id_inst, 32'h1000_0000 + e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_ce", {31'b0, rom_ce}, 32'd0);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_pc_out", id_pc, 32'h0);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ce_after_rst", {31'b0, rom_ce}, 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; id_ready = 1'b0; br = 1'b0; tgt = '0; fl = 1'b0; npc = '0;

    #2;
    chk("reset_ce", {31'b0, rom_ce}, 32'd0);
    chk("reset_valid", {31'b0, id_valid}, 32'd0);
    chk("reset_pc_out", id_pc, 32'h0);
    chk("reset_inst_out", id_inst, 32'h0);
    chk("reset_addr", rom_addr, 32'h0);

    @(negedge clk);
    rst = 1'b0; id_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_ce", {31'b0, rom_ce}, 32'd1);
    chk("first_not_valid", {31'b0, id_valid}, 32'd0);

    // Streaming one per cycle from reset.
    for (int i = 0; i < 5; i++) expect_pc(32'(4 * i));
    repeat (6) tick();

    // Asynchronous reset mid-stream, then stall until the queue fills.
    reset_pulse();
    id_ready = 1'b0;
    repeat (8) tick();
    chk("stall_pc_hold", rom_addr, 32'h10);
    chk("stall_valid", {31'b0, id_valid}, 32'd1);
    chk("stall_head", id_pc, 32'h0);
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_pc(32'(4 * i));
    repeat (5) tick();

    // Branch with queue {20,24,28}, decode stalled: delay slot 20 kept alone.
    id_ready = 1'b0; fl = 1'b1; npc = 32'h20;
    tick();
    fl = 1'b0;
    chk("flush_valid", {31'b0, id_valid}, 32'd0);
    chk("flush_addr", rom_addr, 32'h20);
    repeat (3) tick();
    br = 1'b1; tgt = 32'h100;
    tick();
    br = 1'b0;
    chk("br_stall_head", id_pc, 32'h20);
    chk("br_stall_addr", rom_addr, 32'h100);
    id_ready = 1'b1;
    expect_pc(32'h20); expect_pc(32'h100); expect_pc(32'h104);
    repeat (3) tick();

    // Same branch with decode ready: 20 delivered during the branch cycle.
    id_ready = 1'b0; fl = 1'b1; npc = 32'h20;
    tick();
    fl = 1'b0;
    repeat (3) tick();
    expect_pc(32'h20); expect_pc(32'h100); expect_pc(32'h104);
    id_ready = 1'b1; br = 1'b1; tgt = 32'h100;
    tick();
    br = 1'b0;
    chk("br_ready_empty", {31'b0, id_valid}, 32'd0);
    repeat (3) tick();

    // Branch on empty queue captures the in-flight fetch; then flush beats branch.
    id_ready = 1'b0; fl = 1'b1; npc = 32'h40;
    tick();
    fl = 1'b0; br = 1'b1; tgt = 32'h200;
    tick();
    br = 1'b0;
    chk("br_empty_head_pc", id_pc, 32'h40);
    chk("br_empty_head_inst", id_inst, 32'h1000_0040);
    chk("br_empty_addr", rom_addr, 32'h200);
    tick();
    fl = 1'b1; npc = 32'h180; br = 1'b1; tgt = 32'h200;
    tick();
    fl = 1'b0; br = 1'b0;
    chk("flush_prio_valid", {31'b0, id_valid}, 32'd0);
    chk("flush_prio_addr", rom_addr, 32'h180);
    expect_pc(32'h180); expect_pc(32'h184);
    id_ready = 1'b1;
    repeat (3) tick();

    // PC wrap at the top of the address space.
    id_ready = 1'b0; fl = 1'b1; npc = 32'hFFFF_FFF8;
    tick();
    fl = 1'b0;
    chk("wrap_addr", rom_addr, 32'hFFFF_FFF8);
    expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC); expect_pc(32'h0); expect_pc(32'h4);
    id_ready = 1'b1;
    repeat (5) tick();

    // Branch in the cycle right after reset (ce still low): queue stays empty.
    #2 rst = 1'b1;
    #1;
    chk("rst2_valid", {31'b0, id_valid}, 32'd0);
    chk("rst2_ce", {31'b0, rom_ce}, 32'd0);
    br = 1'b1; tgt = 32'h300;
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    br = 1'b0;
    chk("br_idle_ce", {31'b0, rom_ce}, 32'd1);
    chk("br_idle_valid", {31'b0, id_valid}, 32'd0);
    chk("br_idle_addr", rom_addr, 32'h300);
    expect_pc(32'h300); expect_pc(32'h304);
    repeat (3) tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
